// File: rtl/wb_data_ram_pkg.sv
// Shared constants and enums for the Wishbone data RAM slave.
package wb_data_ram_pkg;
  localparam logic [31:0] DEF_BASE_ADDR  = 32'h3000_0000;
  localparam int          DEF_ADDR_WIDTH = 8;
  localparam logic [15:0] DEF_SIG_OFFSET = 16'h8000;

  typedef enum logic [1:0] {REG_RAM, REG_SIG, REG_NONE} region_e;
  typedef enum logic       {ST_CLEAR, ST_IDLE}          clr_state_e;
endpackage

// File: rtl/wb_data_ram_if.sv
// Wishbone-classic slave bus bundle (wbs_* side of the management SoC).
interface wb_data_ram_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
                  input  wbs_ack_o, wbs_dat_o);
  modport slave  (input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
                  output wbs_ack_o, wbs_dat_o);
endinterface

// File: rtl/wb_data_ram_mem.sv
// Single-port synchronous RAM, byte write enables, registered read-first data.
// Kept standalone so a foundry SRAM macro can replace it.
module wb_data_ram_mem #(
  parameter int AW = 8
) (
  input  logic          i_clk,
  input  logic          i_en,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);
  for (genvar b = 0; b < 4; b++) begin : g_lane
    logic [7:0] r_lane [2**AW];
    logic [7:0] r_rd;

    always_ff @(posedge i_clk) begin
      if (i_en)    r_rd           <= r_lane[i_addr];
      if (i_we[b]) r_lane[i_addr] <= i_wdata[8*b +: 8];
    end

    assign o_rdata[8*b +: 8] = r_rd;
  end
endmodule

// File: rtl/wb_data_ram.sv
// Wishbone data RAM plus 16-bit signature register for firmware progress.
// Optional DATA_RAM_CLEAR_EN: zero every RAM word after reset before serving requests.
module wb_data_ram
  import wb_data_ram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = DEF_BASE_ADDR,
  parameter int          ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter logic [15:0] SIG_OFFSET = DEF_SIG_OFFSET
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  wb_data_ram_if.slave  wbs,
  output logic [15:0]   sig_o
);
  localparam logic [16:0] RAM_BYTES = 17'(4 * (2**ADDR_WIDTH));

  logic                  w_sel, w_req, w_busy;
  region_e               w_region, r_region;
  logic                  r_ack;
  logic [15:0]           r_sig, r_sig_rd;
  logic                  w_mem_en;
  logic [3:0]            w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [31:0]           w_mem_wdata, w_ram_rdata;

  assign w_sel = wbs.wbs_cyc_i & wbs.wbs_stb_i & (wbs.wbs_adr_i[31:16] == BASE_ADDR[31:16]);
  // Ack blocks the following cycle, so a held strobe is serviced every other clock.
  assign w_req = w_sel & ~r_ack & ~w_busy;

  always_comb begin
    w_region = REG_NONE;
    if ({1'b0, wbs.wbs_adr_i[15:0]} < RAM_BYTES)           w_region = REG_RAM;
    else if (wbs.wbs_adr_i[15:2] == SIG_OFFSET[15:2])      w_region = REG_SIG;
  end

`ifdef DATA_RAM_CLEAR_EN
  clr_state_e            r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_clr_idx;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state   <= ST_CLEAR;
      r_clr_idx <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_CLEAR) r_clr_idx <= r_clr_idx + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_CLEAR && r_clr_idx == '1) w_state_nxt = ST_IDLE;
  end

  assign w_busy = (r_state == ST_CLEAR);
`else
  assign w_busy = 1'b0;
`endif

  always_comb begin
    w_mem_addr  = wbs.wbs_adr_i[ADDR_WIDTH+1:2];
    w_mem_wdata = wbs.wbs_dat_i;
    w_mem_en    = w_req & (w_region == REG_RAM);
    w_mem_we    = (w_mem_en & wbs.wbs_we_i) ? wbs.wbs_sel_i : 4'h0;
`ifdef DATA_RAM_CLEAR_EN
    if (w_busy) begin
      w_mem_addr  = r_clr_idx;
      w_mem_wdata = '0;
      w_mem_en    = 1'b0;
      w_mem_we    = 4'hF;
    end
`endif
  end

  wb_data_ram_mem #(.AW(ADDR_WIDTH)) u_mem (
    .i_clk   (wb_clk_i),
    .i_en    (w_mem_en),
    .i_we    (w_mem_we),
    .i_addr  (w_mem_addr),
    .i_wdata (w_mem_wdata),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_ack    <= 1'b0;
      r_region <= REG_NONE;
      r_sig    <= '0;
      r_sig_rd <= '0;
    end else begin
      r_ack <= w_req;
      if (w_req) begin
        r_region <= w_region;
        r_sig_rd <= (w_region == REG_SIG) ? r_sig : '0;
        if (wbs.wbs_we_i && w_region == REG_SIG) begin
          if (wbs.wbs_sel_i[0]) r_sig[7:0]  <= wbs.wbs_dat_i[7:0];
          if (wbs.wbs_sel_i[1]) r_sig[15:8] <= wbs.wbs_dat_i[15:8];
        end
      end
    end
  end

  // RAM data comes straight from the macro's output register; other regions from r_sig_rd.
  assign wbs.wbs_ack_o = r_ack;
  assign wbs.wbs_dat_o = (r_region == REG_RAM) ? w_ram_rdata : {16'h0, r_sig_rd};
  assign sig_o         = r_sig;
endmodule

// File: tb/tb_wb_data_ram.sv
// Self-checking bench for wb_data_ram: vector table, fill/readback, handshake corners.
module tb_wb_data_ram;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sig;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] sb[$];

`ifdef DATA_RAM_CLEAR_EN
  localparam int CLR_CYC = 256;
`else
  localparam int CLR_CYC = 0;
`endif

  wb_data_ram_if bif();

  wb_data_ram dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs      (bif),
    .sig_o    (sig)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    int          kind;   // 0 none, 1 read data, 2 signature after write
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                      input logic [31:0] dat, input int kind, input logic [31:0] exp,
                      input int exp_lat);
    int          lat;
    logic [31:0] e;
    if (kind != 0) sb.push_back(exp);
    bif.wbs_cyc_i = 1'b1; bif.wbs_stb_i = 1'b1; bif.wbs_we_i = we;
    bif.wbs_sel_i = sel;  bif.wbs_adr_i = adr;  bif.wbs_dat_i = dat;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bif.wbs_ack_o && lat < 400);
    check("ack_latency", 32'(lat), 32'(exp_lat));
    if (kind != 0) begin
      e = sb.pop_front();
      if (bif.wbs_ack_o) begin
        if (kind == 1) check("read_data", bif.wbs_dat_o, e);
        else           check("sig_in_ack_cycle", {16'h0, sig}, e);
      end
    end
    bif.wbs_cyc_i = 1'b0; bif.wbs_stb_i = 1'b0; bif.wbs_we_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (CLR_CYC) @(posedge clk);
  endtask

  initial begin
    int          acks;
    logic [31:0] mid_exp;
    logic [5:0]  pat;

    tbl[0]  = '{1'b1, 32'h3000_0000, 4'hF, 32'hDEADBEEF, 0, 32'h0};
    tbl[1]  = '{1'b0, 32'h3000_0000, 4'hF, 32'h0,        1, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, 32'h3000_8000, 4'hF, 32'h0000AB60, 2, 32'h0000AB60};
    tbl[3]  = '{1'b1, 32'h3000_8000, 4'hF, 32'hFFFFAB61, 2, 32'h0000AB61};
    tbl[4]  = '{1'b0, 32'h3000_8000, 4'hF, 32'h0,        1, 32'h0000AB61};
    tbl[5]  = '{1'b1, 32'h3000_0014, 4'hF, 32'h11223344, 0, 32'h0};
    tbl[6]  = '{1'b1, 32'h3000_0014, 4'h9, 32'hAA5566BB, 0, 32'h0};
    tbl[7]  = '{1'b0, 32'h3000_0014, 4'hF, 32'h0,        1, 32'hAA2233BB};
    tbl[8]  = '{1'b1, 32'h3000_0014, 4'h0, 32'hFFFFFFFF, 0, 32'h0};
    tbl[9]  = '{1'b0, 32'h3000_0017, 4'hF, 32'h0,        1, 32'hAA2233BB};
    tbl[10] = '{1'b1, 32'h3000_0400, 4'hF, 32'h12345678, 0, 32'h0};
    tbl[11] = '{1'b0, 32'h3000_0400, 4'hF, 32'h0,        1, 32'h0};
    tbl[12] = '{1'b1, 32'h3000_8000, 4'h2, 32'hFFFF12FF, 2, 32'h00001261};
    tbl[13] = '{1'b0, 32'h3000_8002, 4'hF, 32'h0,        1, 32'h00001261};

    bif.wbs_cyc_i = 1'b0; bif.wbs_stb_i = 1'b0; bif.wbs_we_i = 1'b0;
    bif.wbs_sel_i = 4'h0; bif.wbs_adr_i = '0;   bif.wbs_dat_i = '0;

    @(posedge clk); #1;
    check("reset_ack", {31'h0, bif.wbs_ack_o}, 32'h0);
    check("reset_dat", bif.wbs_dat_o, 32'h0);
    check("reset_sig", {16'h0, sig}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (CLR_CYC) @(posedge clk);

    for (int i = 0; i < 14; i++)
      xfer(tbl[i].we, tbl[i].adr, tbl[i].sel, tbl[i].dat, tbl[i].kind, tbl[i].exp, 1);

    for (int i = 0; i < 256; i++)
      xfer(1'b1, 32'h3000_0000 + 32'(4 * i), 4'hF, 32'(i), 0, 32'h0, 1);
    for (int i = 0; i < 256; i++)
      xfer(1'b0, 32'h3000_0000 + 32'(4 * i), 4'hF, 32'h0, 1, 32'(i), 1);
    xfer(1'b1, 32'h3000_0400, 4'hF, 32'hFFFFFFFF, 0, 32'h0, 1);
    xfer(1'b0, 32'h3000_03FC, 4'hF, 32'h0, 1, 32'd255, 1);
    xfer(1'b0, 32'h3000_0400, 4'hF, 32'h0, 1, 32'h0, 1);

    // Outside the window: never acked.
    acks = 0;
    bif.wbs_cyc_i = 1'b1; bif.wbs_stb_i = 1'b1; bif.wbs_adr_i = 32'h3001_0000;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bif.wbs_ack_o) acks++;
    end
    check("unselected_acks", 32'(acks), 32'h0);

    // Held strobe: expect 0,1,0,1,0,1.
    bif.wbs_adr_i = 32'h3000_0010;
    pat = '0;
    for (int i = 0; i < 6; i++) begin
      pat[i] = bif.wbs_ack_o;
      @(posedge clk); #1;
    end
    check("held_stb_pattern", {26'h0, pat}, 32'h2A);
    bif.wbs_cyc_i = 1'b0; bif.wbs_stb_i = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Reset during an ack: ack drops immediately, committed write survives.
    bif.wbs_cyc_i = 1'b1; bif.wbs_stb_i = 1'b1; bif.wbs_we_i = 1'b1;
    bif.wbs_sel_i = 4'hF; bif.wbs_adr_i = 32'h3000_001C; bif.wbs_dat_i = 32'h5A5A5A5A;
    @(posedge clk); #1;
    check("midrst_ack_before", {31'h0, bif.wbs_ack_o}, 32'h1);
    rst = 1'b1;
    #1;
    check("midrst_ack_cleared", {31'h0, bif.wbs_ack_o}, 32'h0);
    check("midrst_sig_cleared", {16'h0, sig}, 32'h0);
    bif.wbs_cyc_i = 1'b0; bif.wbs_stb_i = 1'b0; bif.wbs_we_i = 1'b0;
    do_reset();
    mid_exp = (CLR_CYC != 0) ? 32'h0 : 32'h5A5A5A5A;
    xfer(1'b0, 32'h3000_001C, 4'hF, 32'h0, 1, mid_exp, 1);

`ifdef DATA_RAM_CLEAR_EN
    xfer(1'b1, 32'h3000_000C, 4'hF, 32'hCAFEF00D, 0, 32'h0, 1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    xfer(1'b0, 32'h3000_000C, 4'hF, 32'h0, 1, 32'h0, 257);
    xfer(1'b1, 32'h3000_000C, 4'hF, 32'hCAFEF00D, 0, 32'h0, 1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (100) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    xfer(1'b0, 32'h3000_000C, 4'hF, 32'h0, 1, 32'h0, 257);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
